sevenseg_scan_ctrl: RTL and testbench
=====================================

// Module: sevenseg_scan_ctrl
// PURPOSE
//  Time-multiplexes NDIG BCD digits onto one shared 4-bit incrementing BCD->7-seg decoder.
//  The decoder is the shared resource: this block feeds it one digit at a time and drives
//  the common-anode digit selects. It also gates the decoder's active-low segments with an
//  anti-ghosting blank window.
//  Sits between the count/value logic (load_* interface) and the board's 7-seg pins.
// PARAMETERS
//  NDIG      4     number of digits scanned (>=2)
//  SCAN_DIV  1000  clk cycles per digit slot (> BLANK_CYC)
//  BLANK_CYC 16    cycles at start of each slot with all anodes off (>=2)
//  PRE_DEC   1     1: dec_bcd = digit-1 mod 10 (the decoder adds 1); 0: dec_bcd = digit
// PORTS
//  clk        in   1       system clock, all logic on rising edge
//  rst_n      in   1       asynchronous active-low reset
//  load_valid in   1       new digit set offered
//  load_ready out  1       pending buffer empty, load accepted this cycle if valid
//  load_bcd   in   4*NDIG  digit i at [4i+3:4i], digit 0 = least significant
//  lz_en      in   1       leading-zero suppression enable
//  dec_bcd    out  4       BCD to shared decoder inputs {Z,Y,X,W} (W = LSB)
//  seg_in     in   7       decoder segments a..g, active-low, combinational from dec_bcd
//  seg_out    out  7       segments to pins, active-low (7'h7F = blank)
//  dig_n      out  NDIG    digit anode selects, active-low
//  frame_tick out  1       1-cycle pulse at each frame boundary
// BEHAVIOUR
//  Reset (async, rst_n=0): cnt=0, idx=0, phase=BLANK, shown digits=0, pending empty,
//   load_ready=1, dig_n=all 1, seg_out=7'h7F, dec_bcd=PRE_DEC?9:0, frame_tick=0.
//  Slot counter cnt counts 0..SCAN_DIV-1. At cnt==SCAN_DIV-1: cnt->0, idx->idx+1 mod NDIG.
//  FSM, two states derived per slot:
//   BLANK (cnt<BLANK_CYC)  -> dig_n all 1, seg_out 7'h7F.
//   SHOW  (cnt>=BLANK_CYC) -> dig_n[idx]=0, others 1.
//   In SHOW: seg_out = suppressed(idx) ? 7'h7F : seg_in.
//   seg_out and dig_n are registered: one cycle behind cnt.
//  dec_bcd is registered and updated on the cycle cnt wraps to 0 (entry to BLANK) to the
//   encoding of the new idx digit, so the decoder settles during the blank window.
//  Digit encoding: valid 0..9 -> dec_bcd = PRE_DEC ? (d==0?9:d-1) : d.
//   Invalid values (10..15) are forced blank in SHOW; dec_bcd is then driven to 0.
//  Leading-zero suppression (lz_en=1): digit i>0 is suppressed if it and every higher
//   digit are 0. Digit 0 is never suppressed. lz_en is sampled with shown digits, per slot.
//  Load handshake:
//   - load_valid && load_ready captures load_bcd into pending; load_ready drops next cycle.
//   - Frame boundary = the cycle with cnt==SCAN_DIV-1 and idx==NDIG-1. At that edge,
//     pending -> shown, pending empties, load_ready=1 next cycle, frame_tick=1 next cycle.
//   - A capture on the boundary cycle itself is not applied until the following frame.
//   - Shown digits never change mid-frame; no tearing.
//   - load_valid while load_ready=0 is ignored. The source must hold the data.
//  Simultaneous events:
//   - Boundary with pending empty: frame_tick still pulses and shown is unchanged.
//   - rst_n low mid-slot: all state returns to reset values immediately. Pending is lost.
//  Width rules: cnt is $clog2(SCAN_DIV) bits and idx is $clog2(NDIG) bits; both wrap
//   explicitly, never on overflow.
// TESTING (NDIG=4, SCAN_DIV=8, BLANK_CYC=2, PRE_DEC=1 unless noted)
//  1 Reset:
//    assert rst_n=0 mid-SHOW -> same cycle dig_n=4'hF, seg_out=7'h7F, load_ready=1;
//    after release dig_n[0] first goes low 3 clks later (cnt=2 + 1 reg).
//  2 Scan timing:
//    load 16'h1234 -> each frame is 32 clks; each dig_n bit low 6 of 8 clks in order 0..3;
//    dec_bcd=3,2,1,0 for digits 4,3,2,1; frame_tick every 32 clks.
//  3 Handshake:
//    offer 16'h5678 mid-frame -> load_ready=0 until the boundary; shown stays 1234 until
//    then; second offer in same frame is not accepted.
//  4 Leading zeros:
//    lz_en=1, load 16'h0070 -> digits 3,2 blank (7'h7F), digits 1,0 show 7 and 0.
//    lz_en=1, load 16'h0000 -> only digit 0 lit.
//  5 Invalid BCD:
//    load 16'h00A0 -> digit 1 blank with dec_bcd=0; others normal.
//  6 PRE_DEC=0:
//    load 16'h0009 -> dec_bcd=9 during digit-0 slot.

Source files
------------

// File: rtl/sevenseg_scan_ctrl.sv
// Scans NDIG BCD digits through one shared (optionally incrementing) BCD->7-seg decoder,
// driving active-low anodes with an all-off blank window at the start of every digit slot.
module sevenseg_scan_ctrl #(
  parameter int NDIG      = 4,
  parameter int SCAN_DIV  = 1000,
  parameter int BLANK_CYC = 16,
  parameter int PRE_DEC   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [4*NDIG-1:0] load_bcd,
  input  logic              lz_en,
  output logic [3:0]        dec_bcd,
  input  logic [6:0]        seg_in,
  output logic [6:0]        seg_out,
  output logic [NDIG-1:0]   dig_n,
  output logic              frame_tick
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NDIG);
  localparam logic [CW-1:0]   CNT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0]   BLANK_END = CW'(BLANK_CYC);
  localparam logic [IW-1:0]   IDX_LAST  = IW'(NDIG - 1);
  localparam logic [NDIG-1:0] ONE_HOT0  = NDIG'(1);
  localparam logic [6:0]      SEG_OFF   = 7'h7F;
  localparam logic [3:0]      DEC_RST   = (PRE_DEC != 0) ? 4'd9 : 4'd0;

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [4*NDIG-1:0] shown_q, shown_d;
  logic [4*NDIG-1:0] pend_q, pend_d;
  logic              pend_vld_q, pend_vld_d;
  logic              lz_q, lz_d;
  logic [3:0]        dec_q, dec_d;
  logic [6:0]        seg_q, seg_d;
  logic [NDIG-1:0]   dig_n_q, dig_n_d;
  logic              tick_q, tick_d;
  logic              wrap, boundary, fire, blank_now;

  function automatic logic [3:0] digit_at(input logic [4*NDIG-1:0] v, input logic [IW-1:0] i);
    logic [3:0] d;
    d = 4'd0;
    for (int j = 0; j < NDIG; j++)
      if (IW'(j) == i) d = v[4*j +: 4];
    return d;
  endfunction

  // The shared decoder adds one when PRE_DEC is set, so the digit is pre-decremented mod 10.
  function automatic logic [3:0] enc(input logic [3:0] d);
    if (d > 4'd9)     return 4'd0;
    if (PRE_DEC == 0) return d;
    return (d == 4'd0) ? 4'd9 : d - 4'd1;
  endfunction

  function automatic logic suppressed(input logic [4*NDIG-1:0] v, input logic [IW-1:0] i,
                                      input logic lz);
    logic hi_zero;
    hi_zero = 1'b1;
    for (int j = 0; j < NDIG; j++)
      if (IW'(j) >= i && v[4*j +: 4] != 4'd0) hi_zero = 1'b0;
    return lz && (i != '0) && hi_zero;
  endfunction

  always_comb begin
    wrap       = (cnt_q == CNT_LAST);
    boundary   = wrap && (idx_q == IDX_LAST);
    fire       = load_valid && !pend_vld_q;
    cnt_d      = wrap ? '0 : cnt_q + 1'b1;
    idx_d      = idx_q;
    if (wrap) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    shown_d    = (boundary && pend_vld_q) ? pend_q : shown_q;
    pend_d     = fire ? load_bcd : pend_q;
    pend_vld_d = pend_vld_q;
    if (boundary && pend_vld_q) pend_vld_d = 1'b0;
    else if (fire)              pend_vld_d = 1'b1;
    lz_d       = wrap ? lz_en : lz_q;
    // Decoder input changes only on slot entry so it settles during the blank window.
    dec_d      = wrap ? enc(digit_at(shown_d, idx_d)) : dec_q;
    state_d    = (cnt_d >= BLANK_END) ? ST_SHOW : ST_BLANK;
    blank_now  = (digit_at(shown_q, idx_q) > 4'd9) || suppressed(shown_q, idx_q, lz_q);
    dig_n_d    = '1;
    seg_d      = SEG_OFF;
    if (state_q == ST_SHOW) begin
      dig_n_d = ~(ONE_HOT0 << idx_q);
      if (!blank_now) seg_d = seg_in;
    end
    tick_d     = boundary;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_BLANK;
      cnt_q      <= '0;
      idx_q      <= '0;
      shown_q    <= '0;
      pend_vld_q <= 1'b0;
      lz_q       <= 1'b0;
      dec_q      <= DEC_RST;
      seg_q      <= SEG_OFF;
      dig_n_q    <= '1;
      tick_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shown_q    <= shown_d;
      pend_vld_q <= pend_vld_d;
      lz_q       <= lz_d;
      dec_q      <= dec_d;
      seg_q      <= seg_d;
      dig_n_q    <= dig_n_d;
      tick_q     <= tick_d;
    end
  end

  // Pending payload is qualified by pend_vld_q, so it carries no reset.
  always_ff @(posedge clk) begin
    pend_q <= pend_d;
  end

  assign load_ready = !pend_vld_q;
  assign dec_bcd    = dec_q;
  assign seg_out    = seg_q;
  assign dig_n      = dig_n_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Bench for sevenseg_scan_ctrl: two instances (incrementing and plain decoder) share stimulus
// and are checked every cycle against a frame/slot arithmetic model plus literal expectations.
module tb_sevenseg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        load_valid = 1'b0;
  logic        lz_en = 1'b0;
  logic [15:0] load_bcd = 16'h0;
  logic        load_ready, load_ready0;
  logic [3:0]  dec_bcd, dec_bcd0;
  logic [6:0]  seg_in, seg_in0, seg_out, seg_out0;
  logic [3:0]  dig_n, dig_n0;
  logic        frame_tick, frame_tick0;

  int tests = 0;
  int fails = 0;
  int cur   = 0;

  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(input int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // Incrementing shared decoder for the PRE_DEC=1 instance, plain decoder for PRE_DEC=0.
  assign seg_in  = glyph((int'(dec_bcd) + 1) % 10);
  assign seg_in0 = glyph(int'(dec_bcd0));

  sevenseg_scan_ctrl #(.NDIG(4), .SCAN_DIV(8), .BLANK_CYC(2), .PRE_DEC(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready),
    .load_bcd(load_bcd), .lz_en(lz_en), .dec_bcd(dec_bcd), .seg_in(seg_in),
    .seg_out(seg_out), .dig_n(dig_n), .frame_tick(frame_tick));

  sevenseg_scan_ctrl #(.NDIG(4), .SCAN_DIV(8), .BLANK_CYC(2), .PRE_DEC(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready0),
    .load_bcd(load_bcd), .lz_en(lz_en), .dec_bcd(dec_bcd0), .seg_in(seg_in0),
    .seg_out(seg_out0), .dig_n(dig_n0), .frame_tick(frame_tick0));

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h, want %h", nm, $time, act, exp);
    end
  endtask

  function automatic int dig(input logic [15:0] v, input int i);
    return int'((v >> (4*i)) & 16'hF);
  endfunction

  function automatic logic blanked(input logic [15:0] v, input int i, input logic lz);
    return (dig(v, i) > 9) || (lz && i > 0 && (v >> (4*i)) == 16'h0);
  endfunction

  // Model: t = rising edges since reset release; slot/phase follow from t by arithmetic.
  int          t;
  int          mc, ms, md;
  logic [15:0] shown_m, shown_p, pend_m;
  logic        pv_m, lz_m, lz_p;
  logic [3:0]  e_dig, e_dec1, e_dec0;
  logic [6:0]  e_seg;
  logic        e_ft;

  always @(negedge clk) begin
    if (!rst_n) begin
      t = 0; shown_m = 16'h0; shown_p = 16'h0; pend_m = 16'h0;
      pv_m = 1'b0; lz_m = 1'b0; lz_p = 1'b0;
      chk("rst_dig_n", 16'(dig_n), 16'hF);
      chk("rst_seg", 16'(seg_out), 16'h7F);
      chk("rst_ready", 16'(load_ready), 16'h1);
      chk("rst_tick", 16'(frame_tick), 16'h0);
      chk("rst_dec", 16'(dec_bcd), 16'h9);
      chk("rst_dec0", 16'(dec_bcd0), 16'h0);
    end else begin
      if (t == 0) begin
        e_dig = 4'hF; e_seg = 7'h7F; e_ft = 1'b0;
      end else begin
        mc = (t - 1) % 8;
        ms = ((t - 1) / 8) % 4;
        e_ft = (t % 32 == 0);
        if (mc < 2) begin
          e_dig = 4'hF; e_seg = 7'h7F;
        end else begin
          e_dig = ~(4'b0001 << ms);
          e_seg = blanked(shown_p, ms, lz_p) ? 7'h7F : glyph(dig(shown_p, ms));
        end
      end
      md = dig(shown_m, (t / 8) % 4);
      e_dec1 = (md > 9) ? 4'd0 : 4'((md + 9) % 10);
      e_dec0 = (md > 9) ? 4'd0 : 4'(md);
      chk("m_dig_n", 16'(dig_n), 16'(e_dig));
      chk("m_seg", 16'(seg_out), 16'(e_seg));
      chk("m_tick", 16'(frame_tick), 16'(e_ft));
      chk("m_ready", 16'(load_ready), 16'(!pv_m));
      chk("m_dec", 16'(dec_bcd), 16'(e_dec1));
      chk("m_dig_n0", 16'(dig_n0), 16'(e_dig));
      chk("m_seg0", 16'(seg_out0), 16'(e_seg));
      chk("m_tick0", 16'(frame_tick0), 16'(e_ft));
      chk("m_ready0", 16'(load_ready0), 16'(!pv_m));
      chk("m_dec0", 16'(dec_bcd0), 16'(e_dec0));
      shown_p = shown_m;
      lz_p    = lz_m;
      if (t % 32 == 31 && pv_m) begin
        shown_m = pend_m; pv_m = 1'b0;
      end else if (load_valid && !pv_m) begin
        pend_m = load_bcd; pv_m = 1'b1;
      end
      if (t % 8 == 7) lz_m = lz_en;
      t++;
    end
  end

  task automatic to_edge(input int k);
    repeat (k - cur) @(posedge clk);
    #2;
    cur = k;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("lit_rst_dig_n", 16'(dig_n), 16'hF);
    chk("lit_rst_dec", 16'(dec_bcd), 16'h9);
    rst_n = 1'b1; cur = 0;
    load_valid = 1'b1; load_bcd = 16'h1234;
    to_edge(1);   load_valid = 1'b0;
    chk("lit_ready_drop", 16'(load_ready), 16'h0);
    to_edge(2);   chk("lit_first_blank", 16'(dig_n), 16'hF);
    to_edge(3);   chk("lit_first_show", 16'(dig_n), 16'hE);
    to_edge(32);  chk("lit_tick1", 16'(frame_tick), 16'h1);
                  chk("lit_dec_d4", 16'(dec_bcd), 16'h3);
                  chk("lit_dec0_d4", 16'(dec_bcd0), 16'h4);
    to_edge(35);  chk("lit_seg_4", 16'(seg_out), 16'h19);
    to_edge(40);  load_valid = 1'b1; load_bcd = 16'h5678;
                  chk("lit_dec_d3", 16'(dec_bcd), 16'h2);
    to_edge(41);  load_valid = 1'b0;
    to_edge(45);  load_valid = 1'b1; load_bcd = 16'h4321;
    to_edge(47);  load_valid = 1'b0;
                  chk("lit_ready_held", 16'(load_ready), 16'h0);
    to_edge(56);  chk("lit_dec_d1", 16'(dec_bcd), 16'h0);
    to_edge(59);  chk("lit_dig3", 16'(dig_n), 16'h7);
                  chk("lit_seg_1", 16'(seg_out), 16'h79);
    to_edge(64);  chk("lit_dec_d8", 16'(dec_bcd), 16'h7);
                  chk("lit_ready_back", 16'(load_ready), 16'h1);
    to_edge(66);  lz_en = 1'b1; load_valid = 1'b1; load_bcd = 16'h0070;
    to_edge(67);  load_valid = 1'b0;
    to_edge(99);  chk("lit_lz_d0", 16'(seg_out), 16'h40);
    to_edge(100); load_valid = 1'b1; load_bcd = 16'h0000;
    to_edge(101); load_valid = 1'b0;
    to_edge(107); chk("lit_lz_d1", 16'(seg_out), 16'h78);
    to_edge(115); chk("lit_lz_d2", 16'(seg_out), 16'h7F);
                  chk("lit_lz_d2_an", 16'(dig_n), 16'hB);
    to_edge(131); chk("lit_zero_d0", 16'(seg_out), 16'h40);
    to_edge(139); chk("lit_zero_d1", 16'(seg_out), 16'h7F);
    to_edge(140); load_valid = 1'b1; load_bcd = 16'h00A0;
    to_edge(141); load_valid = 1'b0;
    to_edge(158); lz_en = 1'b0;
    to_edge(163); chk("lit_inv_d0", 16'(seg_out), 16'h40);
    to_edge(165); load_valid = 1'b1; load_bcd = 16'h0009;
    to_edge(166); load_valid = 1'b0;
    to_edge(168); chk("lit_inv_dec", 16'(dec_bcd), 16'h0);
                  chk("lit_inv_dec0", 16'(dec_bcd0), 16'h0);
    to_edge(171); chk("lit_inv_seg", 16'(seg_out), 16'h7F);
    to_edge(179); chk("lit_inv_d2", 16'(seg_out), 16'h40);
    to_edge(192); chk("lit_nine_dec", 16'(dec_bcd), 16'h8);
                  chk("lit_nine_dec0", 16'(dec_bcd0), 16'h9);
    to_edge(195); chk("lit_nine_seg0", 16'(seg_out0), 16'h10);
    to_edge(224); chk("lit_empty_tick", 16'(frame_tick), 16'h1);
                  chk("lit_empty_dec", 16'(dec_bcd), 16'h8);
    to_edge(255); load_valid = 1'b1; load_bcd = 16'h0321;
    to_edge(256); load_valid = 1'b0;
                  chk("lit_bnd_dec", 16'(dec_bcd), 16'h8);
                  chk("lit_bnd_ready", 16'(load_ready), 16'h0);
    to_edge(288); chk("lit_bnd_applied", 16'(dec_bcd), 16'h0);
    to_edge(289); load_valid = 1'b1; load_bcd = 16'h7777;
    to_edge(290); load_valid = 1'b0;
    to_edge(293); chk("lit_pre_rst_dig", 16'(dig_n), 16'hE);
    rst_n = 1'b0;
    #1;
    chk("lit_async_dig_n", 16'(dig_n), 16'hF);
    chk("lit_async_seg", 16'(seg_out), 16'h7F);
    chk("lit_async_ready", 16'(load_ready), 16'h1);
    chk("lit_async_dec", 16'(dec_bcd), 16'h9);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1; cur = 0;
    to_edge(2);   chk("lit_rel_blank", 16'(dig_n), 16'hF);
    to_edge(3);   chk("lit_rel_show", 16'(dig_n), 16'hE);
                  chk("lit_rel_seg", 16'(seg_out), 16'h40);
    to_edge(40);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

endmodule
